wave_shaper_pwm: RTL and testbench
==================================

Name: wave_shaper_pwm

Overview:
Downstream consumer of the Wavegen sawtooth counter. Takes its 11-bit phase word and shapes it into saw, square, triangle or inverted-saw. Applies a 4-bit volume scale and drives a 1-bit PWM audio output with a 2048-clock period. One new sample is latched per PWM period, so duty never changes mid-period.

Parameters:
- PWM_BITS, 11, width of PWM counter and level; period = 2^PWM_BITS clocks.
- VOL_BITS, 4, width of volume input; scale = volume / 2^VOL_BITS.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- phase  input  11  sawtooth phase from Wavegen out; sampled, not assumed stable.
- wave_sel  input  2  00 saw, 01 square, 10 triangle, 11 inverted saw.
- volume  input  4  amplitude scale, 0 = mute, 15 = 15/16.
- enable  input  1  run/hold control.
- pwm_out  output  1  registered PWM bit to audio filter/jack.
- sample_strobe  output  1  one-cycle pulse when a new level takes effect.
- level  output  11  currently active PWM compare level.

Behaviour:
- Reset (async, rst=1): cnt=0, phase_q=0, level=0, pwm_out=0, sample_strobe=0. It holds while rst is high and takes effect immediately, including mid-period. The first period after release runs at level 0.
- cnt: 11-bit, increments on each edge with enable=1 and wraps 2047->0. It holds when enable=0.
- Stage 1: on the enabled edge where cnt==2046, phase_q <= phase.
- Stage 2: on the enabled edge where cnt==2047, level <= scale(shape(phase_q, wave_sel), volume).
  - wave_sel and volume are sampled only at this edge.
  - Mid-period changes on these inputs are ignored.
- shape (11-bit, unsigned):
  - 00: phase_q.
  - 01: phase_q[10] ? 2047 : 0.
  - 10, t = {phase_q[9:0],1'b0}: phase_q[10]==0 ? t : 2047 - t.
  - 11: 2047 - phase_q.
- scale: level = (shape * volume) >> 4.
  - Use a 15-bit product and truncate, no rounding.
  - Maximum level is 1919.
- sample_strobe: registered. It is 1 for exactly the cycle following the stage-2 edge (cnt==0 in that cycle) and 0 otherwise.
- pwm_out: on every enabled edge, pwm_out <= (cnt < level), using pre-edge values. Within a period it is high for exactly level cycles, lagging cnt by one cycle.
  - level=0: constant low.
  - Duty is never 100%.
- enable=0: pwm_out <= 0 on the next edge. cnt, phase_q and level hold, and no strobe is issued.
  - On re-enable, counting resumes from the held cnt.
  - If enable drops exactly on a cnt==2046/2047 edge, that capture is skipped and occurs when cnt next reaches that value while enabled.
- Simultaneous rst and any other input: rst wins.
- Pipeline latency is phase sample -> level active = 2 edges; level -> first PWM high = 1 cycle.

Test Plan:
- Reset/idle:
  - Stimulus: assert rst mid-period, release, enable=1, phase=0, any wave_sel.
  - Response: pwm_out=0, level=0 for the first 2048 cycles; sample_strobe pulses at cnt==0 of the second period (2048 cycles after release).
- Saw scaling:
  - Stimulus: wave_sel=00, phase=1024 held, volume=15.
  - Response: after the next strobe, level=960; pwm_out high for exactly 960 of 2048 cycles, first high one cycle after cnt==0.
- Square max:
  - Stimulus: wave_sel=01, phase=0x400, volume=15.
  - Response: level=1919.
  - Stimulus: then phase=0x3FF.
  - Response: level=0 next period, pwm_out constant 0.
- Triangle fold:
  - Stimulus: wave_sel=10, phase=0x500, volume=8.
  - Response: level=767.
  - Stimulus: phase=0x100, volume=8.
  - Response: level=256.
- Mid-period change ignored:
  - Stimulus: set wave_sel/volume/phase at cnt==1000.
  - Response: level unchanged until the strobe; new value reflects inputs present at the cnt==2046/2047 edges only.
- Enable hold:
  - Stimulus: drop enable at cnt==500 for 100 cycles, then re-enable.
  - Response: pwm_out=0 during the hold; cnt resumes at 500; no strobe during the hold; next strobe 1548 enabled cycles later.

Source files
------------

// File: rtl/wave_shaper_pwm.sv
// Shapes the Wavegen sawtooth phase into one of four waveforms, scales it by
// volume and drives a 1-bit PWM output whose level is reloaded once per period.
module wave_shaper_pwm #(
    parameter int PWM_BITS = 11,
    parameter int VOL_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] phase,
    input  logic [1:0]          wave_sel,
    input  logic [VOL_BITS-1:0] volume,
    input  logic                enable,
    output logic                pwm_out,
    output logic                sample_strobe,
    output logic [PWM_BITS-1:0] level
);

    localparam int PROD_BITS = PWM_BITS + VOL_BITS;
    localparam logic [PWM_BITS-1:0] ALL_ONES    = '1;
    localparam logic [PWM_BITS-1:0] CNT_LAST    = ALL_ONES;
    localparam logic [PWM_BITS-1:0] CNT_CAPTURE = ALL_ONES - 1'b1;

    logic [PWM_BITS-1:0]  cnt_reg;
    logic [PWM_BITS-1:0]  phase_q_reg;
    logic [PWM_BITS-1:0]  tri_fold;
    logic [PWM_BITS-1:0]  shape_next;
    logic [PWM_BITS-1:0]  level_next;
    logic [PROD_BITS-1:0] partial [VOL_BITS];
    logic [PROD_BITS-1:0] product;

    // Triangle: the lower phase bits doubled, mirrored in the upper half-period.
    assign tri_fold = {phase_q_reg[PWM_BITS-2:0], 1'b0};

    always_comb begin
        shape_next = phase_q_reg;
        case (wave_sel)
            2'b00:   shape_next = phase_q_reg;
            2'b01:   shape_next = phase_q_reg[PWM_BITS-1] ? ALL_ONES : '0;
            2'b10:   shape_next = phase_q_reg[PWM_BITS-1] ? (ALL_ONES - tri_fold) : tri_fold;
            default: shape_next = ALL_ONES - phase_q_reg;
        endcase
    end

    // Shift-and-add multiply: one partial product per volume bit.
    genvar gi;
    generate
        for (gi = 0; gi < VOL_BITS; gi++) begin : g_pp
            assign partial[gi] = volume[gi] ? (PROD_BITS'(shape_next) << gi) : '0;
        end
    endgenerate

    always_comb begin
        product = '0;
        for (int i = 0; i < VOL_BITS; i++) begin
            product = product + partial[i];
        end
    end

    // Dropping the low VOL_BITS divides by 2^VOL_BITS with truncation.
    assign level_next = product[PROD_BITS-1:VOL_BITS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg       <= '0;
            phase_q_reg   <= '0;
            level         <= '0;
            pwm_out       <= 1'b0;
            sample_strobe <= 1'b0;
        end else begin
            sample_strobe <= enable && (cnt_reg == CNT_LAST);
            if (enable) begin
                cnt_reg <= cnt_reg + 1'b1;
                pwm_out <= (cnt_reg < level);
                if (cnt_reg == CNT_CAPTURE) begin
                    phase_q_reg <= phase;
                end
                if (cnt_reg == CNT_LAST) begin
                    level <= level_next;
                end
            end else begin
                pwm_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wave_shaper_pwm.sv
// Self-checking bench for wave_shaper_pwm: directed scenarios plus randomized
// stimulus against a per-period arithmetic reference model.
module tb_wave_shaper_pwm;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] phase;
    logic [1:0]  wave_sel;
    logic [3:0]  volume;
    logic        enable;
    logic        pwm_out;
    logic        sample_strobe;
    logic [10:0] level;

    int n_total = 0;
    int n_bad   = 0;
    bit chk_on  = 1'b0;

    // Reference model state: position within the period, captured phase, level.
    int m_n   = 0;
    int m_pq  = 0;
    int m_lvl = 0;
    bit m_pwm = 1'b0;
    bit m_stb = 1'b0;

    wave_shaper_pwm dut (
        .clk           (clk),
        .rst           (rst),
        .phase         (phase),
        .wave_sel      (wave_sel),
        .volume        (volume),
        .enable        (enable),
        .pwm_out       (pwm_out),
        .sample_strobe (sample_strobe),
        .level         (level)
    );

    always #5 clk = ~clk;

    function automatic int shape_ref(int p, int sel);
        case (sel)
            0:       return p;
            1:       return (p >= 1024) ? 2047 : 0;
            2:       return (p < 1024) ? 2 * p : 2047 - 2 * (p - 1024);
            default: return 2047 - p;
        endcase
    endfunction

    function automatic int scale_ref(int s, int v);
        return (s * v) / 16;
    endfunction

    task automatic chk(string tag, int obs, int exp);
        n_total++;
        if (obs != exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s got=%0d want=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_n   <= 0;
            m_pq  <= 0;
            m_lvl <= 0;
            m_pwm <= 1'b0;
            m_stb <= 1'b0;
        end else if (enable) begin
            m_pwm <= (m_n < m_lvl);
            if (m_n == 2046) m_pq <= int'(phase);
            if (m_n == 2047) begin
                m_lvl <= scale_ref(shape_ref(m_pq, int'(wave_sel)), int'(volume));
                m_stb <= 1'b1;
            end else begin
                m_stb <= 1'b0;
            end
            m_n <= (m_n + 1) % 2048;
        end else begin
            m_pwm <= 1'b0;
            m_stb <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_level", int'(level), m_lvl);
            chk("model_pwm", int'(pwm_out), int'(m_pwm));
            chk("model_strobe", int'(sample_strobe), int'(m_stb));
            if (sample_strobe)
                $display("sample t=%0t level=%0d sel=%0d vol=%0d", $time, level, wave_sel, volume);
        end
    end

    task automatic wait_strobe(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sample_strobe && n < 6000);
        if (!sample_strobe) chk("strobe_timeout", 0, 1);
    endtask

    task automatic wait_pos(input int k);
        int n = 0;
        while (m_n != k && n < 6000) begin
            @(negedge clk);
            n++;
        end
        if (m_n != k) chk("pos_timeout", m_n, k);
    endtask

    // Counts pwm highs over the 2048 cycles following the current strobe cycle.
    task automatic measure_period(output int highs);
        highs = 0;
        for (int i = 0; i < 2048; i++) begin
            @(negedge clk);
            if (i == 0) chk("first_high", int'(pwm_out), int'(level != 0));
            highs += int'(pwm_out);
        end
    endtask

    task automatic apply_and_check(input int p, input int w, input int v,
                                   input int exp_lvl, input string tag);
        int n;
        int highs;
        phase    = 11'(p);
        wave_sel = 2'(w);
        volume   = 4'(v);
        wait_strobe(n);
        wait_strobe(n);
        chk({tag, "_level"}, int'(level), exp_lvl);
        measure_period(highs);
        chk({tag, "_duty"}, highs, exp_lvl);
        $display("directed %s level=%0d highs=%0d", tag, level, highs);
    endtask

    initial begin
        int n;
        int highs;
        int stbs;
        int old_lvl;

        rst = 1'b1; enable = 1'b0; phase = '0; wave_sel = 2'b00; volume = 4'd15;
        repeat (3) @(negedge clk);
        chk("rst_level", int'(level), 0);
        chk("rst_pwm", int'(pwm_out), 0);
        chk("rst_strobe", int'(sample_strobe), 0);
        rst = 1'b0; enable = 1'b1;
        chk_on = 1'b1;

        // First period after release runs at level 0; strobe lands 2048 edges later.
        highs = 0; n = 0;
        do begin
            @(negedge clk);
            n++;
            highs += int'(pwm_out);
        end while (!sample_strobe && n < 3000);
        chk("idle_strobe_at", n, 2048);
        chk("idle_highs", highs, 0);

        apply_and_check(1024, 0, 15, 960, "saw");
        apply_and_check(11'h400, 1, 15, 1919, "sqmax");
        apply_and_check(11'h3FF, 1, 15, 0, "sqzero");
        apply_and_check(11'h500, 2, 8, 767, "trifold");
        apply_and_check(11'h100, 2, 8, 256, "tririse");
        apply_and_check(11'h7FF, 3, 15, 0, "invmin");

        // Mid-period change: only values at the capture edges matter.
        wait_strobe(n);
        old_lvl = int'(level);
        wait_pos(1000);
        phase = 11'h200; wave_sel = 2'b00; volume = 4'd15;
        wait_pos(2000);
        chk("mid_hold", int'(level), old_lvl);
        wait_pos(2047);
        phase = 11'h7FF; volume = 4'd8;
        wait_strobe(n);
        chk("mid_new", int'(level), 256);

        // Enable hold at cnt==500 for 100 cycles.
        wait_pos(500);
        enable = 1'b0;
        highs = 0; stbs = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            highs += int'(pwm_out);
            stbs  += int'(sample_strobe);
        end
        chk("hold_pwm", highs, 0);
        chk("hold_strobe", stbs, 0);
        chk("hold_level", int'(level), 256);
        enable = 1'b1;
        wait_strobe(n);
        chk("resume_gap", n, 1548);

        // Asynchronous reset mid-period clears everything immediately.
        phase = 11'h600; wave_sel = 2'b00; volume = 4'd15;
        wait_strobe(n);
        wait_strobe(n);
        wait_pos(700);
        #3 rst = 1'b1;
        #1;
        chk("arst_level", int'(level), 0);
        chk("arst_pwm", int'(pwm_out), 0);
        @(negedge clk);
        rst = 1'b0; phase = '0;
        highs = 0; n = 0;
        do begin
            @(negedge clk);
            n++;
            highs += int'(pwm_out);
        end while (!sample_strobe && n < 3000);
        chk("arst_strobe_at", n, 2048);
        chk("arst_highs", highs, 0);

        // Randomized run, checked cycle by cycle against the model.
        for (int i = 0; i < 16384; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 99) < 3) phase = 11'($urandom);
            if ($urandom_range(0, 999) < 4) wave_sel = 2'($urandom);
            if ($urandom_range(0, 999) < 4) volume = 4'($urandom);
            if ($urandom_range(0, 999) < 3) enable = ~enable;
            if (!enable && $urandom_range(0, 99) < 2) enable = 1'b1;
            if (i == 9000) begin
                #2 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
